// File: rtl/pic_sequencer_if.sv
// Bus between the PIC instruction sequencer and the instruction memory / ALU / register file.
// The sequencer side is the master; the datapath side is the slave.
interface pic_sequencer_if #(
  parameter int PC_WIDTH       = 13,
  parameter int STK_DEPTH_LOG2 = 3
);
  logic                      run;
  logic [13:0]               instr;
  logic                      zero;
  logic [PC_WIDTH-1:0]       pc;
  logic                      imem_en;
  logic                      alu_en;
  logic                      reg_we;
  logic                      w_we;
  logic [STK_DEPTH_LOG2-1:0] stk_ptr;
  logic                      skip_active;
  logic                      stk_overflow;
  logic                      stk_underflow;
  logic                      busy;

  modport master (
    input  run, instr, zero,
    output pc, imem_en, alu_en, reg_we, w_we, stk_ptr,
           skip_active, stk_overflow, stk_underflow, busy
  );

  modport slave (
    output run, instr, zero,
    input  pc, imem_en, alu_en, reg_we, w_we, stk_ptr,
           skip_active, stk_overflow, stk_underflow, busy
  );
endinterface

// File: rtl/pic_sequencer.sv
// Four-phase (FETCH/DECODE/EXEC/WB) instruction sequencer for the 14-bit PIC-style core.
// Owns the program counter and the circular return stack; all outputs decode registered state.
module pic_sequencer #(
  parameter int PC_WIDTH       = 13,
  parameter int STK_DEPTH_LOG2 = 3
) (
  input logic             clk,
  input logic             reset_n,
  pic_sequencer_if.master bus
);

  localparam int DEPTH = 2 ** STK_DEPTH_LOG2;
  localparam logic [STK_DEPTH_LOG2:0] FULL = (STK_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB} state_t;

  state_t                    state, state_nx;
  logic [13:0]               ir;
  logic [PC_WIDTH-1:0]       pc_q;
  logic [STK_DEPTH_LOG2-1:0] sp;
  logic [STK_DEPTH_LOG2-1:0] sp_dec;
  logic [STK_DEPTH_LOG2:0]   cnt;
  logic                      ovf, unf, skip;
  logic [PC_WIDTH-1:0]       stack [DEPTH];

  logic is_ret, is_retlw, is_call, is_goto;
  logic dec_reg, dec_w;
  logic skip_on_z, skip_on_nz, skip_take;
  logic [PC_WIDTH-1:0] target;
  logic imem_en, alu_en, reg_we, w_we;

  assign is_ret     = (ir == 14'h0008);
  assign is_retlw   = (ir[13:10] == 4'b1101);
  assign is_call    = (ir[13:11] == 3'b100);
  assign is_goto    = (ir[13:11] == 3'b101);
  assign target     = PC_WIDTH'(ir[10:0]);
  assign skip_on_z  = (ir[13:8] == 6'h0B) || (ir[13:8] == 6'h0F) || (ir[13:10] == 4'b0110);
  assign skip_on_nz = (ir[13:10] == 4'b0111);
  assign skip_take  = (skip_on_z && bus.zero) || (skip_on_nz && !bus.zero);
  assign sp_dec     = sp - 1'b1;

  always_comb begin
    dec_reg = 1'b0;
    dec_w   = 1'b0;
    unique case (ir[13:12])
      2'b00: begin
        if (ir != 14'h0000 && ir != 14'h0008) begin
          dec_reg = ir[7];
          dec_w   = !ir[7];
        end
      end
      2'b01:   dec_reg = !ir[11];
      2'b10:   ;
      default: dec_w = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    imem_en  = 1'b0;
    alu_en   = 1'b0;
    reg_we   = 1'b0;
    w_we     = 1'b0;
    unique case (state)
      IDLE:   if (bus.run) state_nx = FETCH;
      FETCH:  begin
        imem_en  = 1'b1;
        state_nx = DECODE;
      end
      DECODE: state_nx = EXEC;
      EXEC:   begin
        alu_en   = !skip;
        state_nx = WB;
      end
      WB:     begin
        reg_we   = !skip && dec_reg;
        w_we     = !skip && dec_w;
        state_nx = bus.run ? FETCH : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == DECODE) ir <= bus.instr;
    end
  end

  // A skipped instruction is a plain increment: no branch, no stack action, no new skip.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= '0;
      sp   <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
      skip <= 1'b0;
    end else if (state == WB) begin
      if (skip) begin
        pc_q <= pc_q + 1'b1;
        skip <= 1'b0;
      end else begin
        skip <= skip_take;
        if (is_call) begin
          pc_q <= target;
          sp   <= sp + 1'b1;
          if (cnt == FULL) ovf <= 1'b1;
          else             cnt <= cnt + 1'b1;
        end else if (is_goto) begin
          pc_q <= target;
        end else if (is_ret || is_retlw) begin
          pc_q <= stack[sp_dec];
          sp   <= sp_dec;
          if (cnt == '0) unf <= 1'b1;
          else           cnt <= cnt - 1'b1;
        end else begin
          pc_q <= pc_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == WB && !skip && is_call) stack[sp] <= pc_q + 1'b1;
  end

  assign bus.pc            = pc_q;
  assign bus.stk_ptr       = sp;
  assign bus.stk_overflow  = ovf;
  assign bus.stk_underflow = unf;
  assign bus.busy          = (state != IDLE);
  assign bus.skip_active   = skip && (state != IDLE);
  assign bus.imem_en       = imem_en;
  assign bus.alu_en        = alu_en;
  assign bus.reg_we        = reg_we;
  assign bus.w_we          = w_we;

endmodule

// File: doc/pic_sequencer.md
# pic_sequencer

Multi-cycle instruction sequencer for the 14-bit PIC-style core. It owns the 13-bit program counter and the 8-entry return stack, and steps each instruction through four phases: FETCH, DECODE, EXEC, WB. It drives the instruction-memory enable, the ALU enable and the register-file and W write enables. It handles conditional-skip, CALL/GOTO/RETURN/RETLW flow control, and run/halt. It sits between `Inst_Memory` and the ALU and register file, and replaces the free-running counter/stack logic.

## Interface

Parameters:
- `PC_WIDTH`, 13: program counter width.
- `STK_DEPTH_LOG2`, 3: log2 of the return-stack depth, giving 8 entries of `PC_WIDTH` bits each.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; sequencer advances while high.
- `instr`  in  14  instruction word from instruction memory; valid during DECODE.
- `zero`  in  1  ALU result-zero flag; valid during WB.
- `pc`  out  13  current program counter; also the instruction-memory address.
- `imem_en`  out  1  instruction-memory read enable.
- `alu_en`  out  1  ALU operate strobe.
- `reg_we`  out  1  general-register-file write enable.
- `w_we`  out  1  W-register write enable.
- `stk_ptr`  out  3  stack pointer; points to the next free entry.
- `skip_active`  out  1  high while the current instruction is being executed as a NOP.
- `stk_overflow`  out  1  sticky; set by a push onto a full stack.
- `stk_underflow`  out  1  sticky; set by a pop from an empty stack.
- `busy`  out  1  high in every state except IDLE.

## Operation

States:
- IDLE: goes to FETCH when `run`=1.
- FETCH → DECODE → EXEC → WB, one cycle each.
- WB: goes to FETCH if `run`=1, otherwise IDLE.

Phase actions:
- FETCH: `imem_en`=1.
- DECODE: `instr` is latched into the internal instruction register `ir`.
- EXEC: `alu_en`=1.
- WB: the write enable is pulsed, the skip condition is evaluated, and `pc` and the stack are updated.

Decode of `ir` (`ir[13:12]` selects the class):
- `00` byte-oriented ops: `ir[7]`=1 selects `reg_we`, otherwise `w_we`.
  - Exceptions: `ir`=0x0008 is RETURN and `ir`=0x0000 is NOP; neither asserts a write enable.
- `01` bit ops, selected by `ir[11:10]`:
  - BCF (`00`) and BSF (`01`): `reg_we`.
  - BTFSC (`10`) and BTFSS (`11`): no write.
- `10` flow control:
  - `ir[11]`=0: CALL.
  - `ir[11]`=1: GOTO.
  - Target address is {2'b00, `ir[10:0]`}.
  - No write enables.
- `11` literal ops: `w_we`. Within this class, RETLW is `ir[11:10]`=`01`.

Skip condition, evaluated in WB:
- DECFSZ (`00_1011`) and INCFSZ (`00_1111`): skip when `zero`=1.
- BTFSC: skip when `zero`=1.
- BTFSS: skip when `zero`=0.
- When the skip is taken, the internal skip flag is set. The next instruction is fetched and decoded normally, but with `alu_en`, `reg_we` and `w_we` forced to 0, and it is treated as a plain increment (no branch, no stack action). `skip_active`=1 from its FETCH through its WB. The flag clears at the end of that WB.

PC update at the end of WB (wraps modulo 2^13):
- CALL: `stack[stk_ptr]` ← `pc`+1, `stk_ptr`+1, `pc` ← target.
- GOTO: `pc` ← target.
- RETURN and RETLW: `stk_ptr`−1, `pc` ← `stack[stk_ptr−1]`.
- All other instructions: `pc` ← `pc`+1.

Stack behaviour:
- The stack is circular and the pointer wraps modulo 8.
- An internal occupancy count runs 0..8 and saturates.
- Push when count=8: the entry is overwritten, `stk_overflow` is set, and the count stays at 8.
- Pop when count=0: `stk_underflow` is set, the stale entry is loaded into `pc` anyway, and the count stays at 0.
- The sticky flags are cleared only by reset.

Halt behaviour:
- Deasserting `run` mid-instruction does not abort the instruction. It completes through WB, then the sequencer enters IDLE with `pc` already advanced.

## Timing

Reset values (`reset_n`=0, takes effect immediately without waiting for `clk`):
- State IDLE.
- `pc`=0, `stk_ptr`=0, count=0.
- `stk_overflow`=0, `stk_underflow`=0.
- Skip flag 0.
- `imem_en`, `alu_en`, `reg_we`, `w_we`, `skip_active` and `busy` all 0.

Reset mid-instruction aborts the instruction: no write enable is asserted after `reset_n` falls.

Output timing:
- All outputs are decoded from registered state: the state register, `ir`, `pc`, `stk_ptr`, the stack count, the sticky flags and the skip flag. No output depends combinationally on `run`, `instr` or `zero`.

Cycle-level behaviour:
- Every instruction, including a skipped one, takes exactly 4 cycles.
- `instr` must be valid in the cycle after FETCH. This matches the registered read of the instruction memory.
- `zero` must be valid during WB. This matches the registered ALU output from EXEC.
- `pc`, `stk_ptr` and the flags change only on the rising edge that ends WB. The exception is asynchronous reset.
- IDLE → FETCH takes 1 cycle after `run`=1 is sampled.

## Test plan

1. Reset, then `run`=1 with MOVLW 0x3005 at address 0 → `imem_en` in cycle 1, `alu_en` in cycle 3, `w_we` in cycle 4, `pc`=1 afterwards, `busy`=1 throughout.
2. CALL 0x123 (0x2123) at `pc`=0x010 → `pc`=0x123, `stk_ptr`=1, stack entry 0x011. Then RETURN (0x0008) at 0x123 → `pc`=0x011, `stk_ptr`=0, no write enables.
3. DECFSZ 0x0BA0 with `zero`=1 in WB → the next instruction (ADDWF d=1) shows `skip_active`=1 with `alu_en`, `reg_we` and `w_we` all 0; `pc` advances by 2 in total. Repeating with `zero`=0 → no skip.
4. Nine nested CALLs → `stk_overflow` rises on the 9th, `stk_ptr` wraps to 1. After reset, a RETURN → `stk_underflow`=1 and `stk_ptr`=7.
5. `run` dropped during EXEC → WB completes, then IDLE with `busy`=0; `pc` is held while `run` stays 0; reasserting `run` resumes FETCH 1 cycle later.
6. `reset_n` pulsed low during WB of ADDWF d=1 → `reg_we` goes to 0 immediately, and `pc`, `stk_ptr` and the flags are 0 before the next `clk` edge.
